// File: rtl/mbb_serial_mac_if.sv
// Operand/result bus of the crumb-serial MAC plus the mBB crumb port.
// The slave side is the MAC; the master side is the requester that also
// hosts the combinational 2x2 mBB.
interface mbb_serial_mac_if #(
  parameter int unsigned ACC_W = 24
);
  logic             i_valid;
  logic             o_ready;
  logic [7:0]       i_a;
  logic [7:0]       i_b;
  logic             i_a_signed;
  logic             i_b_signed;
  logic [1:0]       i_prec;
  logic             i_acc_clr;
  logic [1:0]       mbb_a;
  logic [1:0]       mbb_b;
  logic [1:0]       mbb_sel;
  logic [3:0]       mbb_p;
  logic             o_valid;
  logic [15:0]      o_product;
  logic [ACC_W-1:0] o_acc;

  modport slave (
    input  i_valid, i_a, i_b, i_a_signed, i_b_signed, i_prec, i_acc_clr, mbb_p,
    output o_ready, mbb_a, mbb_b, mbb_sel, o_valid, o_product, o_acc
  );

  modport master (
    output i_valid, i_a, i_b, i_a_signed, i_b_signed, i_prec, i_acc_clr, mbb_p,
    input  o_ready, mbb_a, mbb_b, mbb_sel, o_valid, o_product, o_acc
  );
endinterface

// File: rtl/mbb_serial_mac.sv
// Crumb-serial multiply-accumulate sequencer around one 2x2 mBB.
// Operands are split into 2-bit crumbs (A inner loop, B outer loop), each
// mBB partial product is extended, shifted and summed into a 16-bit product,
// which is then added to (or loaded into) the accumulator.
// Build option: define MBB_SERIAL_SAT_EN for a saturating accumulator;
// otherwise the accumulator wraps.
module mbb_serial_mac #(
  parameter int unsigned ACC_W = 24
) (
  input logic           clk,
  input logic           nrst,
  mbb_serial_mac_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       a_q, b_q;
  logic             a_signed_q, b_signed_q, acc_clr_q;
  logic [1:0]       last_q;  // N-1: index of the top crumb
  logic [1:0]       i_q, j_q;
  logic [15:0]      psum_q, psum_d;
  logic [15:0]      product_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_ext, acc_base;
  logic [1:0]       prec_last;
  logic [1:0]       sel;
  logic [15:0]      p_ext;
  logic [2:0]       ij_sum;
  logic [3:0]       shamt;
  logic             accept, run, last_step, any_signed;

  assign accept     = (state_q == StIdle) && bus.i_valid;
  assign run        = (state_q == StRun);
  assign last_step  = run && (i_q == last_q) && (j_q == last_q);
  assign any_signed = a_signed_q | b_signed_q;
  // Reserved precision 11 behaves as 8-bit.
  assign prec_last  = (bus.i_prec == 2'b00) ? 2'd0 : (bus.i_prec == 2'b01) ? 2'd1 : 2'd3;

  // Crumb drive to the mBB; only the top crumb of a signed operand is signed.
  always_comb begin
    bus.mbb_a = 2'b00;
    bus.mbb_b = 2'b00;
    sel       = 2'b00;
    if (run) begin
      bus.mbb_a = a_q[{i_q, 1'b0} +: 2];
      bus.mbb_b = b_q[{j_q, 1'b0} +: 2];
      sel       = {a_signed_q && (i_q == last_q), b_signed_q && (j_q == last_q)};
    end
  end

  assign bus.mbb_sel = sel;

  // Extend, weight by 4^(i+j) and add the current mBB result.
  always_comb begin
    p_ext  = (sel == 2'b00) ? {12'b0, bus.mbb_p} : {{12{bus.mbb_p[3]}}, bus.mbb_p};
    ij_sum = {1'b0, i_q} + {1'b0, j_q};
    shamt  = {ij_sum, 1'b0};
    psum_d = psum_q + (p_ext << shamt);
  end

  // Final product extended from bit 4N-1 of the running partial sum.
  always_comb begin
    case (last_q)
      2'd0:    prod_d = any_signed ? {{12{psum_d[3]}}, psum_d[3:0]} : {12'b0, psum_d[3:0]};
      2'd1:    prod_d = any_signed ? {{8{psum_d[7]}}, psum_d[7:0]} : {8'b0, psum_d[7:0]};
      default: prod_d = psum_d;
    endcase
  end

`ifdef MBB_SERIAL_SAT_EN
  logic [ACC_W:0] sum_w;

  // Saturating accumulate; the extra top bit of the widened sum flags overflow.
  always_comb begin
    acc_ext  = any_signed ? ACC_W'($signed(prod_d)) : ACC_W'(prod_d);
    acc_base = acc_clr_q ? '0 : acc_q;
    if (any_signed) begin
      sum_w = {acc_base[ACC_W-1], acc_base} + {acc_ext[ACC_W-1], acc_ext};
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        acc_d = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end else begin
      sum_w = {1'b0, acc_base} + {1'b0, acc_ext};
      acc_d = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
    end
  end
`else
  // Wrapping accumulate.
  always_comb begin
    acc_ext  = any_signed ? ACC_W'($signed(prod_d)) : ACC_W'(prod_d);
    acc_base = acc_clr_q ? '0 : acc_q;
    acc_d    = acc_base + acc_ext;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.i_valid) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand latch, crumb counters, partial sum and result registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      acc_clr_q  <= 1'b0;
      last_q     <= '0;
      i_q        <= '0;
      j_q        <= '0;
      psum_q     <= '0;
      product_q  <= '0;
      acc_q      <= '0;
    end else begin
      if (accept) begin
        a_q        <= bus.i_a;
        b_q        <= bus.i_b;
        a_signed_q <= bus.i_a_signed;
        b_signed_q <= bus.i_b_signed;
        acc_clr_q  <= bus.i_acc_clr;
        last_q     <= prec_last;
        i_q        <= '0;
        j_q        <= '0;
        psum_q     <= '0;
      end
      if (run) begin
        psum_q <= psum_d;
        if (i_q == last_q) begin
          i_q <= '0;
          if (j_q != last_q) j_q <= j_q + 2'd1;
        end else begin
          i_q <= i_q + 2'd1;
        end
      end
      if (last_step) begin
        product_q <= prod_d;
        acc_q     <= acc_d;
      end
    end
  end

  assign bus.o_ready   = (state_q == StIdle);
  assign bus.o_valid   = (state_q == StDone);
  assign bus.o_product = product_q;
  assign bus.o_acc     = acc_q;

endmodule

// File: tb/tb_mbb_serial_mac.sv
// Directed bench for mbb_serial_mac: a 24-bit and a 16-bit accumulator
// instance receive identical stimulus, each with its own 2x2 mBB model.
module tb_mbb_serial_mac;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [1:0] sel_log [16];
  logic       saw_valid;

  always #5 clk = ~clk;

  mbb_serial_mac_if #(.ACC_W(24)) bus24 ();
  mbb_serial_mac_if #(.ACC_W(16)) bus16 ();

  mbb_serial_mac #(.ACC_W(24)) dut24 (.clk(clk), .nrst(nrst), .bus(bus24));
  mbb_serial_mac #(.ACC_W(16)) dut16 (.clk(clk), .nrst(nrst), .bus(bus16));

  // 2x2 mBB: crumb operands signed when their sel bit is set, 4-bit result.
  function automatic logic [3:0] mbb_mul(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] sel);
    int av, bv;
    av = int'(a);
    bv = int'(b);
    if (sel[1] && a[1]) av = av - 4;
    if (sel[0] && b[1]) bv = bv - 4;
    return 4'(av * bv);
  endfunction

  assign bus24.mbb_p = mbb_mul(bus24.mbb_a, bus24.mbb_b, bus24.mbb_sel);
  assign bus16.mbb_p = mbb_mul(bus16.mbb_a, bus16.mbb_b, bus16.mbb_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic as, input logic bs, input logic [1:0] prec,
                       input logic clr);
    bus24.i_valid = v;   bus16.i_valid = v;
    bus24.i_a = a;       bus16.i_a = a;
    bus24.i_b = b;       bus16.i_b = b;
    bus24.i_a_signed = as; bus16.i_a_signed = as;
    bus24.i_b_signed = bs; bus16.i_b_signed = bs;
    bus24.i_prec = prec; bus16.i_prec = prec;
    bus24.i_acc_clr = clr; bus16.i_acc_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for o_valid; leaves the bench in the DONE cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic as, input logic bs, input logic [1:0] prec,
                        input logic clr, input int exp_lat);
    int n;
    check({tag, "_ready"}, 32'(bus24.o_ready), 32'd1);
    drive(1'b1, a, b, as, bs, prec, clr);
    tick();
    // Scramble inputs after accept; they must have no effect.
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    n = 0;
    while (bus24.o_valid !== 1'b1 && n < 40) begin
      if (n < 16) sel_log[n] = bus24.mbb_sel;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n + 1), 32'(exp_lat));
    check({tag, "_valid16"}, 32'(bus16.o_valid), 32'd1);
  endtask

  task automatic end_op(input string tag);
    tick();
    check({tag, "_pulse"}, 32'(bus24.o_valid), 32'd0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    nrst = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    check("rst_ready", 32'(bus24.o_ready), 32'd1);
    check("rst_valid", 32'(bus24.o_valid), 32'd0);
    check("rst_product", 32'(bus24.o_product), 32'h0);
    check("rst_acc", 32'(bus24.o_acc), 32'h0);
    check("rst_sel", 32'(bus24.mbb_sel), 32'h0);

    // 8-bit UU 255*255, clear.
    run_op("uu8", 8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 1'b1, 17);
    check("uu8_product", 32'(bus24.o_product), 32'hFE01);
    check("uu8_acc", 32'(bus24.o_acc), 32'h00FE01);
    check("uu8_acc16", 32'(bus16.o_acc), 32'hFE01);
    end_op("uu8");

    // 8-bit SS -128*-128, clear.
    run_op("ss8a", 8'h80, 8'h80, 1'b1, 1'b1, 2'b10, 1'b1, 17);
    check("ss8a_product", 32'(bus24.o_product), 32'h4000);
    check("ss8a_acc", 32'(bus24.o_acc), 32'h004000);
    end_op("ss8a");

    // 8-bit SS -1*127, accumulate.
    run_op("ss8b", 8'hFF, 8'h7F, 1'b1, 1'b1, 2'b10, 1'b0, 17);
    check("ss8b_product", 32'(bus24.o_product), 32'hFF81);
    check("ss8b_acc", 32'(bus24.o_acc), 32'h003F81);
    check("ss8b_acc16", 32'(bus16.o_acc), 32'h3F81);
    end_op("ss8b");

    // 2-bit SS -2*-2 with junk in the unused high bits.
    run_op("ss2", 8'hFE, 8'hA2, 1'b1, 1'b1, 2'b00, 1'b1, 2);
    check("ss2_sel", 32'(sel_log[0]), 32'h3);
    check("ss2_product", 32'(bus24.o_product), 32'h0004);
    check("ss2_acc", 32'(bus24.o_acc), 32'h000004);
    end_op("ss2");

    // 4-bit A unsigned 15, B signed -8, accumulate onto 4.
    run_op("us4", 8'h3F, 8'h08, 1'b0, 1'b1, 2'b01, 1'b0, 5);
    check("us4_sel0", 32'(sel_log[0]), 32'h0);
    check("us4_sel1", 32'(sel_log[1]), 32'h0);
    check("us4_sel2", 32'(sel_log[2]), 32'h1);
    check("us4_sel3", 32'(sel_log[3]), 32'h1);
    check("us4_product", 32'(bus24.o_product), 32'hFF88);
    check("us4_acc", 32'(bus24.o_acc), 32'hFFFF8C);
    check("us4_acc16", 32'(bus16.o_acc), 32'hFF8C);
    end_op("us4");

    // 16-bit accumulator overflow: 255*255 twice.
    run_op("ov1", 8'hFF, 8'hFF, 1'b0, 1'b0, 2'b11, 1'b1, 17);
    check("ov1_acc16", 32'(bus16.o_acc), 32'hFE01);
    end_op("ov1");
    run_op("ov2", 8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10, 1'b0, 17);
    check("ov2_product16", 32'(bus16.o_product), 32'hFE01);
    check("ov2_acc24", 32'(bus24.o_acc), 32'h01FC02);
`ifdef MBB_SERIAL_SAT_EN
    check("ov2_acc16", 32'(bus16.o_acc), 32'hFFFF);
`else
    check("ov2_acc16", 32'(bus16.o_acc), 32'hFC02);
`endif
    end_op("ov2");

    // Reset during RUN cycle 5 of an 8-bit op.
    saw_valid = 1'b0;
    drive(1'b1, 8'h03, 8'h05, 1'b0, 1'b0, 2'b10, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int k = 1; k < 5; k++) begin
      if (bus24.o_valid === 1'b1) saw_valid = 1'b1;
      tick();
    end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    check("abort_valid", 32'(bus24.o_valid), 32'd0);
    check("abort_acc", 32'(bus24.o_acc), 32'h0);
    check("abort_product", 32'(bus24.o_product), 32'h0);
    check("abort_ready", 32'(bus24.o_ready), 32'd1);

    // New op right after the abort: -127 (signed) * 200 (unsigned).
    run_op("post", 8'h81, 8'hC8, 1'b1, 1'b0, 2'b10, 1'b0, 17);
    check("post_product", 32'(bus24.o_product), 32'h9CC8);
    check("post_acc", 32'(bus24.o_acc), 32'hFF9CC8);
    check("post_acc16", 32'(bus16.o_acc), 32'h9CC8);
    end_op("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
